// File: rtl/rr_arb_4ch.sv
// Four-channel round-robin arbiter with a registered output slot.
// The grant scan starts at ptr, and ptr moves past the winner after each accepted beat.
module rr_arb_4ch #(
  parameter int DW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_sel,
  input  logic            out_ready
);

  logic [1:0] ptr;
  logic [1:0] win;
  logic       found;
  logic       load;
  logic       xfer;
  logic [1:0] idx;

  assign load = !out_valid || out_ready;
  assign xfer = load && found && !rst;

  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = 4'b0000;
    if (xfer) in_ready[win] = 1'b1;
  end

  // Output slot and pointer; an idle load edge only clears valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[win*DW +: DW];
        out_sel   <= win;
        ptr       <= win + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_4ch.sv
// Self-checking bench for rr_arb_4ch: table of vectors with hand-derived expectations,
// and a scoreboard queue of granted beats that is checked against the registered output.
module tb_rr_arb_4ch;

  localparam int DW = 4;

  logic            clk;
  logic            rst;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_ready;

  int total;
  int bad;

  typedef struct {
    logic            r;
    logic [3:0]      v;
    logic [4*DW-1:0] d;
    logic            ordy;
    logic [3:0]      er;
    logic            eov;
    logic [1:0]      esel;
    logic [DW-1:0]   edat;
  } vec_t;

  vec_t vecs[$];
  logic [5:0] sbq[$];

  rr_arb_4ch #(.DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic [3:0] v, input logic ordy,
                        input logic [3:0] er, input logic eov,
                        input logic [1:0] esel, input logic [DW-1:0] edat);
    vec_t t;
    t.r = r; t.v = v; t.d = 16'h3914; t.ordy = ordy;
    t.er = er; t.eov = eov; t.esel = esel; t.edat = edat;
    vecs.push_back(t);
  endtask

  // Drive at the falling edge, check in_ready mid-cycle, outputs just after the rising edge.
  task automatic applyStimulus(input vec_t t, input int n);
    logic [1:0] gsel;
    logic [5:0] sb;
    @(negedge clk);
    rst       = t.r;
    in_valid  = t.v;
    in_data   = t.d;
    out_ready = t.ordy;
    #1;
    checkOutput($sformatf("in_ready[%0d]", n), 32'(in_ready), 32'(t.er));
    if (t.er != 4'b0000) begin
      gsel = 2'd0;
      for (int i = 0; i < 4; i++) if (t.er[i]) gsel = 2'(i);
      sbq.push_back({gsel, t.d[gsel*DW +: DW]});
    end
    @(posedge clk);
    #1;
    checkOutput($sformatf("out_valid[%0d]", n), 32'(out_valid), 32'(t.eov));
    if (t.er != 4'b0000) begin
      if (sbq.size() == 0) begin
        checkOutput($sformatf("sb_empty[%0d]", n), 32'd0, 32'd1);
      end else begin
        sb = sbq.pop_front();
        checkOutput($sformatf("sb_sel[%0d]", n), 32'(out_sel), 32'(sb[5:4]));
        checkOutput($sformatf("sb_data[%0d]", n), 32'(out_data), 32'(sb[3:0]));
      end
    end else begin
      checkOutput($sformatf("hold_sel[%0d]", n), 32'(out_sel), 32'(t.esel));
      checkOutput($sformatf("hold_data[%0d]", n), 32'(out_data), 32'(t.edat));
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 4'hF;
    in_data = 16'h3914;
    out_ready = 1'b1;

    // Reset with all channels requesting.
    addVec(1, 4'hF, 1, 4'b0000, 0, 2'd0, 4'd0);
    addVec(1, 4'hF, 1, 4'b0000, 0, 2'd0, 4'd0);
    // Full contention: 0,1,2,3,0.
    addVec(0, 4'hF, 1, 4'b0001, 1, 2'd0, 4'd4);
    addVec(0, 4'hF, 1, 4'b0010, 1, 2'd1, 4'd1);
    addVec(0, 4'hF, 1, 4'b0100, 1, 2'd2, 4'd9);
    addVec(0, 4'hF, 1, 4'b1000, 1, 2'd3, 4'd3);
    addVec(0, 4'hF, 1, 4'b0001, 1, 2'd0, 4'd4);
    // Grant ch3 so ptr wraps to 0, then sparse ch1/ch2.
    addVec(0, 4'b1000, 1, 4'b1000, 1, 2'd3, 4'd3);
    addVec(0, 4'b0110, 1, 4'b0010, 1, 2'd1, 4'd1);
    addVec(0, 4'b0110, 1, 4'b0100, 1, 2'd2, 4'd9);
    // Backpressure for 3 cycles, then release without a bubble.
    addVec(0, 4'hF, 0, 4'b0000, 1, 2'd2, 4'd9);
    addVec(0, 4'hF, 0, 4'b0000, 1, 2'd2, 4'd9);
    addVec(0, 4'hF, 0, 4'b0000, 1, 2'd2, 4'd9);
    addVec(0, 4'hF, 1, 4'b1000, 1, 2'd3, 4'd3);
    // Grant ch1, idle twice (ptr stays 2), then ch2 wins.
    addVec(0, 4'b0010, 1, 4'b0010, 1, 2'd1, 4'd1);
    addVec(0, 4'b0000, 1, 4'b0000, 0, 2'd1, 4'd1);
    addVec(0, 4'b0000, 1, 4'b0000, 0, 2'd1, 4'd1);
    addVec(0, 4'hF, 1, 4'b0100, 1, 2'd2, 4'd9);
    // Stalled beat dropped by reset; restart grants ch0.
    addVec(0, 4'hF, 0, 4'b0000, 1, 2'd2, 4'd9);
    addVec(1, 4'hF, 0, 4'b0000, 0, 2'd0, 4'd0);
    addVec(0, 4'hF, 1, 4'b0001, 1, 2'd0, 4'd4);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    checkOutput("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
